symmetrical_pwm_multi: RTL
==========================

# symmetrical_pwm_multi

Multi-channel, centre-aligned (symmetrical) PWM generator with its own triangular carrier, per-channel shadowed compare registers, complementary outputs with programmable dead-time, per-channel override and a trip/enable path that re-arms only at the carrier valley. It is the parametrised next generation of the single-channel symmetrical PWM and drives the converter bridge legs directly. Compare and period values come from the control datapath.

## Interface
Parameters:
- CHANNELS, 4, number of bridge legs (complementary output pairs).
- WIDTH, 16, carrier, period and compare width (unsigned).
- DT_WIDTH, 8, dead-time counter width.

Ports:
- clk_i  in  1  single clock for the whole block.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  trip/enable; low = outputs off.
- period_i  in  WIDTH  carrier peak value P; sampled at valley.
- duty_i  in  CHANNELS*WIDTH  compare values; channel k at [k*WIDTH +: WIDTH].
- duty_we_i  in  CHANNELS  per-channel shadow write strobe.
- deadtime_i  in  DT_WIDTH  dead-time in clocks, common to all channels; sampled at valley.
- override_i  in  2*CHANNELS  per-channel mode: 00 normal, 01 force lo on, 10 force hi on, 11 both off.
- pwm_hi_o  out  CHANNELS  high-side gate outputs.
- pwm_lo_o  out  CHANNELS  low-side gate outputs.
- counter_o  out  WIDTH  carrier value.
- valley_o  out  1  high while counter_o==0.
- peak_o  out  1  high while counter_o==P (active period).

## Operation
- Carrier: counts 0,1,…,P,P-1,…,1,0,…; carrier period is 2P clocks. Active P and dead-time are reloaded when counter_o==0. P==0: counter holds 0; valley_o is high every cycle; peak_o is also high.
- Shadow: duty_we_i[k] writes duty_i slice k into shadow[k]. Each shadow is copied to its active compare at the valley. A write in the valley cycle itself is loaded directly, bypassing the shadow.
- Raw compare: raw[k] = (counter_o < active_cmp[k]).
  - cmp=0 gives 0 % duty.
  - cmp>P gives 100 % duty.
- Dead-time channel:
  - On a raw edge, the turning-off output drops after the base latency.
  - The turning-on output rises only after a further DT clocks of unchanged raw.
  - A raw toggle during the dead window restarts the count; the pending output never asserts.
  - DT=0 gives a pure complementary pair. hi and lo are never both high.
- Override is applied after dead-time. 01/10 force the named output high and the other low; they ignore dead-time.
- Trip: enable_i low clears the enabled flag; all outputs go 0 on the next edge, override included. The flag sets again only at a valley with enable_i high; outputs resume from that valley.
- Reset values:
  - Counter 0, direction up.
  - Active P 0, shadows and active compares 0.
  - Enabled flag 0, dead-time counters 0.
  - All pwm outputs 0.

## Timing
- counter_o, valley_o and peak_o are registered; they reflect the same cycle's count.
- Base latency is 1 clock: a compare decided on counter value n is visible on the pwm outputs in the cycle after counter_o==n.
- Turn-on latency is 1+DT clocks.
- Trip latency is 1 clock from enable_i low.
- Re-arm: first non-zero output one clock after the valley that samples enable_i high.
- Shadow to active takes effect in the carrier period starting at the load valley.
- Simultaneous trip and valley: trip wins, and the block stays disabled.
- Reset mid-period forces the reset values immediately (asynchronous); restart is from count 0.

## Structure
- Shared package `pwm_pkg`:
  - override mode constants (OVR_NORMAL, OVR_LO, OVR_HI, OVR_OFF);
  - default WIDTH and DT_WIDTH.
- Sub-module `pwm_deadtime_channel`: one per channel, instantiated by generate. It contains the shadow and active compare, raw compare, dead-time counter, override and enable gating.
- The top level holds the carrier, the period/dead-time reload and the enabled flag.

## Test plan
- P=10, cmp=4, DT=0, enabled: per 20-clock period pwm_hi_o high 7 clocks (counter 0–3 up, 3–1 down), pwm_lo_o high 13 clocks; valley_o once and peak_o once per 20 clocks.
- Same with DT=2: hi high 5 clocks, lo high 11 clocks, 2-clock both-low gaps at each edge. Assert hi&lo is never 1.
- Write cmp=8 mid-period via duty_we_i: no change until the next valley, then hi high 15 clocks per period. Write coincident with the valley loads immediately.
- cmp=0 gives hi always 0 and lo always 1. cmp=11 (>P) gives hi always 1 and lo always 0; no dead-time gaps.
- enable_i low mid-period: all outputs 0 on the next clock. enable_i high again mid-period: outputs stay 0 until one clock after the next valley.
- Override 10 on ch1 and 11 on ch2 while ch0 is normal: ch1 hi=1/lo=0, ch2 both 0, ch0 unaffected. Assert rst_ni mid-period: all outputs and counter_o are 0 immediately.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the symmetrical PWM block.
// Override mode codes and default widths.
package pwm_pkg;

   localparam int PWM_WIDTH_DEF    = 16;
   localparam int PWM_DT_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      OVR_NORMAL = 2'b00,
      OVR_LO     = 2'b01,
      OVR_HI     = 2'b10,
      OVR_OFF    = 2'b11
   } ovr_e;

endpackage

// File: rtl/pwm_deadtime_channel.sv
// One bridge leg: shadowed compare, raw compare,
// dead-time insertion, override and enable gating.
module pwm_deadtime_channel
   import pwm_pkg::*;
#(
   parameter int WIDTH    = PWM_WIDTH_DEF,
   parameter int DT_WIDTH = PWM_DT_WIDTH_DEF
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [WIDTH-1:0]    counter_i,
   input  logic                valley_i,
   input  logic [WIDTH-1:0]    duty_i,
   input  logic                duty_we_i,
   input  logic [DT_WIDTH-1:0] deadtime_i,
   input  logic [1:0]          override_i,
   input  logic                en_i,
   output logic                hi_o,
   output logic                lo_o
);

   logic [WIDTH-1:0]    shadow_q;
   logic [WIDTH-1:0]    active_q;
   logic [WIDTH-1:0]    cmp_eff;
   logic                raw;
   logic                raw_q;
   logic [DT_WIDTH-1:0] stab_q;
   logic [DT_WIDTH-1:0] stab_d;
   logic                settled;
   logic                hi_d;
   logic                lo_d;
   logic                hi_q;
   logic                lo_q;

   // Compare select: a valley write bypasses the shadow.
   always_comb begin
      cmp_eff = active_q;
      if (valley_i) begin
         cmp_eff = duty_we_i ? duty_i : shadow_q;
      end
      raw = (counter_i < cmp_eff);
      stab_d = '0;
      if (raw == raw_q) begin
         stab_d = (&stab_q) ? stab_q
                            : stab_q + DT_WIDTH'(1);
      end
      settled = (stab_d >= deadtime_i);
   end

   // Dead-time result, then override on top of it.
   always_comb begin
      hi_d = 1'b0;
      lo_d = 1'b0;
      unique case (ovr_e'(override_i))
         OVR_NORMAL: begin
            hi_d = raw & settled;
            lo_d = ~raw & settled;
         end
         OVR_LO:  lo_d = 1'b1;
         OVR_HI:  hi_d = 1'b1;
         OVR_OFF: ;
      endcase
   end

   // Shadow, active compare, stability count, gated outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= '0;
         active_q <= '0;
         raw_q    <= 1'b0;
         stab_q   <= '0;
         hi_q     <= 1'b0;
         lo_q     <= 1'b0;
      end else begin
         if (duty_we_i) begin
            shadow_q <= duty_i;
         end
         if (valley_i) begin
            active_q <= cmp_eff;
         end
         raw_q  <= raw;
         stab_q <= stab_d;
         hi_q   <= en_i & hi_d;
         lo_q   <= en_i & lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/symmetrical_pwm_multi.sv
// Multi-channel centre-aligned PWM: triangular carrier,
// period/dead-time reload at valley, trip/re-arm flag.
module symmetrical_pwm_multi
   import pwm_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = PWM_WIDTH_DEF,
   parameter int DT_WIDTH = PWM_DT_WIDTH_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      enable_i,
   input  logic [WIDTH-1:0]          period_i,
   input  logic [CHANNELS*WIDTH-1:0] duty_i,
   input  logic [CHANNELS-1:0]       duty_we_i,
   input  logic [DT_WIDTH-1:0]       deadtime_i,
   input  logic [2*CHANNELS-1:0]     override_i,
   output logic [CHANNELS-1:0]       pwm_hi_o,
   output logic [CHANNELS-1:0]       pwm_lo_o,
   output logic [WIDTH-1:0]          counter_o,
   output logic                      valley_o,
   output logic                      peak_o
);

   logic [WIDTH-1:0]    counter_q;
   logic [WIDTH-1:0]    counter_d;
   logic                dir_up_q;
   logic                dir_up_d;
   logic [WIDTH-1:0]    period_q;
   logic [WIDTH-1:0]    period_d;
   logic [DT_WIDTH-1:0] dt_q;
   logic [DT_WIDTH-1:0] dt_d;
   logic                valley_q;
   logic                peak_q;
   logic                en_q;
   logic                en_d;

   // Carrier next state; reload happens in the valley cycle.
   always_comb begin
      counter_d = counter_q;
      dir_up_d  = dir_up_q;
      period_d  = period_q;
      dt_d      = dt_q;
      if (valley_q) begin
         period_d  = period_i;
         dt_d      = deadtime_i;
         dir_up_d  = 1'b1;
         counter_d = (period_i == '0) ? '0 : WIDTH'(1);
      end else if (dir_up_q && (counter_q < period_q)) begin
         counter_d = counter_q + WIDTH'(1);
      end else begin
         dir_up_d  = 1'b0;
         counter_d = counter_q - WIDTH'(1);
      end
      // Trip wins over a coincident valley re-arm.
      en_d = enable_i & (en_q | valley_q);
   end

   // Carrier, flags and enabled state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         counter_q <= '0;
         dir_up_q  <= 1'b1;
         period_q  <= '0;
         dt_q      <= '0;
         valley_q  <= 1'b1;
         peak_q    <= 1'b1;
         en_q      <= 1'b0;
      end else begin
         counter_q <= counter_d;
         dir_up_q  <= dir_up_d;
         period_q  <= period_d;
         dt_q      <= dt_d;
         valley_q  <= (counter_d == '0);
         peak_q    <= (counter_d == period_d);
         en_q      <= en_d;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      pwm_deadtime_channel #(
         .WIDTH    (WIDTH),
         .DT_WIDTH (DT_WIDTH)
      ) u_ch (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .counter_i  (counter_q),
         .valley_i   (valley_q),
         .duty_i     (duty_i[k*WIDTH +: WIDTH]),
         .duty_we_i  (duty_we_i[k]),
         .deadtime_i (dt_q),
         .override_i (override_i[2*k +: 2]),
         .en_i       (en_d),
         .hi_o       (pwm_hi_o[k]),
         .lo_o       (pwm_lo_o[k])
      );
   end

   assign counter_o = counter_q;
   assign valley_o  = valley_q;
   assign peak_o    = peak_q;

endmodule
